// File: rtl/posit_divider_8bit_seq.sv
// posit_divider_8bit_seq
//   Sequential posit8 (es=0) divider: quotient = lhs / rhs.
//   One operation in flight; restoring division, one quotient bit per cycle.
//
// Ports
//   clk        sole clock, rising edge
//   rst        synchronous, active-high reset
//   in_valid   operand pair offered          in_ready   high only in IDLE
//   lhs, rhs   dividend / divisor (posit8)
//   out_valid  quotient available            out_ready  consumer accepts quotient
//   quotient   lhs/rhs (posit8), held until the output handshake
//
// Configuration
//   POSIT_DIV_SPECIAL_FASTPATH_EN  defined: NaR/zero cases jump from DECODE to
//   DONE (out_valid 2 cycles after accept). Undefined: they walk through DIVIDE
//   and ROUND with the result forced, giving a constant 12-cycle latency.
//
// Timing: accept edge -> DECODE(1) -> DIVIDE(9) -> ROUND(1) -> DONE; out_valid
// is raised by the first DONE cycle, i.e. 12 edges after accept.

module posit_divider_8bit_seq (
  input  logic       clk,
  input  logic       rst,
  input  logic       in_valid,
  output logic       in_ready,
  input  logic [7:0] lhs,
  input  logic [7:0] rhs,
  output logic       out_valid,
  input  logic       out_ready,
  output logic [7:0] quotient
);

  typedef enum logic [2:0] {IDLE, DECODE, DIVIDE, ROUND, DONE} state_t;

  state_t            state_q, state_d;
  logic [7:0]        lhs_q, lhs_d, rhs_q, rhs_d;
  logic              sign_q, sign_d;
  logic signed [4:0] scale_q, scale_d;
  logic              special_q, special_d;
  logic [5:0]        mant_b_q, mant_b_d;
  logic [6:0]        rem_q, rem_d;
  logic [8:0]        quot_q, quot_d;
  logic [3:0]        cnt_q, cnt_d;
  logic [7:0]        result_q, result_d;
  logic [7:0]        quotient_q, quotient_d;
  logic              out_valid_q, out_valid_d;

  // Returns {scale[4:0], frac[4:0]}; frac is left-aligned below the hidden bit.
  function automatic logic [9:0] decode_posit(input logic [7:0] p);
    logic [6:0]        mag;
    logic [2:0]        run;
    logic              stop;
    logic signed [4:0] sc;
    logic [4:0]        fr;
    mag  = p[7] ? (~p[6:0] + 7'd1) : p[6:0];
    run  = 3'd0;
    stop = 1'b0;
    for (int i = 6; i >= 0; i--) begin
      if (!stop) begin
        if (mag[i] == mag[6]) run = run + 3'd1;
        else                  stop = 1'b1;
      end
    end
    sc = mag[6] ? ($signed({2'b00, run}) - 5'sd1) : -$signed({2'b00, run});
    // Drop regime and terminator, keep the next five bits.
    fr = 5'((mag << ({1'b0, run} + 4'd1)) >> 2);
    return {sc, fr};
  endfunction

  logic [9:0] dec_l, dec_r;
  logic       lhs_nar, rhs_nar, lhs_zero, rhs_zero, is_special;
  logic [7:0] special_val;

  assign dec_l    = decode_posit(lhs_q);
  assign dec_r    = decode_posit(rhs_q);
  assign lhs_nar  = (lhs_q == 8'h80);
  assign rhs_nar  = (rhs_q == 8'h80);
  assign lhs_zero = (lhs_q == 8'h00);
  assign rhs_zero = (rhs_q == 8'h00);
  assign is_special  = lhs_nar | rhs_nar | rhs_zero | lhs_zero;
  assign special_val = (lhs_nar | rhs_nar | rhs_zero) ? 8'h80 : 8'h00;

  // Restoring division step.
  logic       div_ge;
  logic [6:0] div_sub;
  assign div_ge  = (rem_q >= {1'b0, mant_b_q});
  assign div_sub = div_ge ? (rem_q - {1'b0, mant_b_q}) : rem_q;

  // Normalise, pack regime+fraction, round to nearest even, saturate, sign.
  logic [7:0]        norm_frac;
  logic signed [4:0] norm_scale, neg_scale_m1;
  logic [16:0]       pack_word;
  logic              round_up;
  logic [7:0]        round_sum;
  logic [6:0]        round_mag;
  logic [7:0]        round_result;

  always_comb begin
    norm_frac    = quot_q[8] ? quot_q[7:0] : {quot_q[6:0], 1'b0};
    norm_scale   = quot_q[8] ? scale_q : (scale_q - 5'sd1);
    neg_scale_m1 = -norm_scale - 5'sd1;
    // Regime grows by arithmetic fill (ones) for k>=0 or zero fill for k<0.
    if (!norm_scale[4])
      pack_word = $signed({2'b10, norm_frac, 7'b0}) >>> norm_scale[2:0];
    else
      pack_word = {2'b01, norm_frac, 7'b0} >> neg_scale_m1[2:0];
    round_up  = pack_word[9] & ((|pack_word[8:0]) | (rem_q != 7'd0) | pack_word[10]);
    round_sum = {1'b0, pack_word[16:10]} + {7'd0, round_up};
    if (norm_scale > 5'sd6)             round_mag = 7'h7F;
    else if (norm_scale < -5'sd6)       round_mag = 7'h01;
    else if (round_sum[7])              round_mag = 7'h7F;
    else if (round_sum[6:0] == 7'd0)    round_mag = 7'h01;
    else                                round_mag = round_sum[6:0];
    round_result = sign_q ? (8'd0 - {1'b0, round_mag}) : {1'b0, round_mag};
  end

  always_comb begin
    state_d     = state_q;
    lhs_d       = lhs_q;
    rhs_d       = rhs_q;
    sign_d      = sign_q;
    scale_d     = scale_q;
    special_d   = special_q;
    mant_b_d    = mant_b_q;
    rem_d       = rem_q;
    quot_d      = quot_q;
    cnt_d       = cnt_q;
    result_d    = result_q;
    quotient_d  = quotient_q;
    out_valid_d = out_valid_q;
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          lhs_d   = lhs;
          rhs_d   = rhs;
          state_d = DECODE;
        end
      end
      DECODE: begin
        sign_d    = lhs_q[7] ^ rhs_q[7];
        scale_d   = $signed(dec_l[9:5]) - $signed(dec_r[9:5]);
        rem_d     = {2'b01, dec_l[4:0]};
        mant_b_d  = {1'b1, dec_r[4:0]};
        quot_d    = 9'd0;
        cnt_d     = 4'd0;
        special_d = is_special;
        result_d  = special_val;
`ifdef POSIT_DIV_SPECIAL_FASTPATH_EN
        state_d   = is_special ? DONE : DIVIDE;
`else
        state_d   = DIVIDE;
`endif
      end
      DIVIDE: begin
        quot_d = {quot_q[7:0], div_ge};
        rem_d  = {div_sub[5:0], 1'b0};
        cnt_d  = cnt_q + 4'd1;
        if (cnt_q == 4'd8) state_d = ROUND;
      end
      ROUND: begin
        if (!special_q) result_d = round_result;
        state_d = DONE;
      end
      DONE: begin
        if (!out_valid_q) begin
          out_valid_d = 1'b1;
          quotient_d  = result_q;
        end else if (out_ready) begin
          out_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= IDLE;
      lhs_q       <= 8'd0;
      rhs_q       <= 8'd0;
      sign_q      <= 1'b0;
      scale_q     <= 5'sd0;
      special_q   <= 1'b0;
      mant_b_q    <= 6'd0;
      rem_q       <= 7'd0;
      quot_q      <= 9'd0;
      cnt_q       <= 4'd0;
      result_q    <= 8'd0;
      quotient_q  <= 8'd0;
      out_valid_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      lhs_q       <= lhs_d;
      rhs_q       <= rhs_d;
      sign_q      <= sign_d;
      scale_q     <= scale_d;
      special_q   <= special_d;
      mant_b_q    <= mant_b_d;
      rem_q       <= rem_d;
      quot_q      <= quot_d;
      cnt_q       <= cnt_d;
      result_q    <= result_d;
      quotient_q  <= quotient_d;
      out_valid_q <= out_valid_d;
    end
  end

  assign in_ready  = (state_q == IDLE);
  assign out_valid = out_valid_q;
  assign quotient  = quotient_q;

endmodule

// File: tb/tb_posit_divider_8bit_seq.sv
// tb_posit_divider_8bit_seq
//   Directed and randomized checks of posit_divider_8bit_seq against a
//   real-valued posit8 reference (nearest representable value, ties to even).

module tb_posit_divider_8bit_seq;

  logic       clk = 1'b0;
  logic       rst;
  logic       in_valid;
  logic       in_ready;
  logic [7:0] lhs, rhs;
  logic       out_valid;
  logic       out_ready;
  logic [7:0] quotient;

  int errors = 0;
  int checks = 0;
  real posval [128];

  always #5 clk = ~clk;

  posit_divider_8bit_seq dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .lhs       (lhs),
    .rhs       (rhs),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .quotient  (quotient)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  function automatic real pow2(input int e);
    real r = 1.0;
    if (e >= 0) for (int i = 0; i < e; i++) r = r * 2.0;
    else        for (int i = 0; i < -e; i++) r = r / 2.0;
    return r;
  endfunction

  // Value of a finite posit8 (es=0), read straight off the bit string.
  function automatic real p2r(input logic [7:0] p);
    logic [7:0] m;
    int run, k, nb, f;
    real r;
    if (p == 8'h00) return 0.0;
    m = p[7] ? (~p + 8'd1) : p;
    run = 1;
    while (run < 7 && m[6-run] == m[6]) run++;
    k  = m[6] ? run - 1 : -run;
    nb = 6 - run;
    if (nb < 0) nb = 0;
    f  = int'(m) % (1 << nb);
    r  = pow2(k) * (1.0 + real'(f) / pow2(nb));
    return p[7] ? -r : r;
  endfunction

  function automatic logic [7:0] model_div(input logic [7:0] a, input logic [7:0] b);
    real q, aq, d, bestd;
    int best;
    logic [7:0] mag;
    if (a == 8'h80 || b == 8'h80 || b == 8'h00) return 8'h80;
    if (a == 8'h00) return 8'h00;
    q  = p2r(a) / p2r(b);
    aq = (q < 0.0) ? -q : q;
    if (aq >= 128.0)            mag = 8'h7F;
    else if (aq < 1.0 / 64.0)   mag = 8'h01;
    else begin
      best = 1;
      bestd = 1.0e9;
      for (int i = 1; i < 128; i++) begin
        d = posval[i] - aq;
        if (d < 0.0) d = -d;
        if (d < bestd || (d == bestd && (i % 2) == 0)) begin
          bestd = d;
          best  = i;
        end
      end
      mag = 8'(best);
    end
    return (q < 0.0) ? (~mag + 8'd1) : mag;
  endfunction

  function automatic bit is_special(input logic [7:0] a, input logic [7:0] b);
    return (a == 8'h80 || b == 8'h80 || a == 8'h00 || b == 8'h00);
  endfunction

  // One full transaction; called on a negedge with the DUT idle.
  task automatic do_op(input logic [7:0] a, input logic [7:0] b, input logic [7:0] exp_q,
                       input int stall, input string tag);
    int n, exp_lat;
    exp_lat = 12;
`ifdef POSIT_DIV_SPECIAL_FASTPATH_EN
    if (is_special(a, b)) exp_lat = 2;
`endif
    n = 0;
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    check_eq({tag, "_in_ready"}, in_ready, 1);
    in_valid  = 1'b1;
    lhs       = a;
    rhs       = b;
    out_ready = 1'b0;
    @(negedge clk);
    n = 0;
    while (!out_valid && n < 40) begin
      in_valid  = 1'($urandom_range(0, 1));
      lhs       = 8'($urandom);
      rhs       = 8'($urandom);
      out_ready = 1'($urandom_range(0, 1));
      @(negedge clk);
      n++;
    end
    if (!out_valid) begin
      check_eq({tag, "_timeout"}, 0, 1);
      in_valid = 1'b0;
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      return;
    end
    check_eq({tag, "_quotient"}, quotient, exp_q);
    check_eq({tag, "_latency"}, n, exp_lat);
    $display("op %s lhs=%h rhs=%h q=%h exp=%h lat=%0d", tag, a, b, quotient, exp_q, n);
    for (int k = 0; k < stall; k++) begin
      in_valid  = 1'($urandom_range(0, 1));
      lhs       = 8'($urandom);
      rhs       = 8'($urandom);
      out_ready = 1'b0;
      @(negedge clk);
      check_eq({tag, "_hold_valid"}, out_valid, 1);
      check_eq({tag, "_hold_q"}, quotient, exp_q);
      check_eq({tag, "_hold_in_ready"}, in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check_eq({tag, "_pulse_end"}, out_valid, 0);
    check_eq({tag, "_idle_again"}, in_ready, 1);
  endtask

  typedef struct { logic [7:0] a; logic [7:0] b; logic [7:0] q; } vec_t;
  vec_t dir [9];

  initial begin
    logic [7:0] a, b;
    bit seen;
    for (int i = 1; i < 128; i++) posval[i] = p2r(8'(i));
    posval[0] = 0.0;

    dir[0] = '{8'h40, 8'h60, 8'h20};
    dir[1] = '{8'h40, 8'h50, 8'h2B};
    dir[2] = '{8'hC0, 8'h60, 8'hE0};
    dir[3] = '{8'h7F, 8'h01, 8'h7F};
    dir[4] = '{8'h01, 8'h7F, 8'h01};
    dir[5] = '{8'h40, 8'h00, 8'h80};
    dir[6] = '{8'h80, 8'h40, 8'h80};
    dir[7] = '{8'h00, 8'h40, 8'h00};
    dir[8] = '{8'h40, 8'h40, 8'h40};

    rst = 1'b1;
    in_valid = 1'b0;
    out_ready = 1'b0;
    lhs = 8'h00;
    rhs = 8'h00;
    repeat (3) @(negedge clk);
    check_eq("reset_out_valid", out_valid, 0);
    check_eq("reset_quotient", quotient, 8'h00);
    rst = 1'b0;
    @(negedge clk);
    check_eq("reset_in_ready", in_ready, 1);

    for (int i = 0; i < 9; i++)
      do_op(dir[i].a, dir[i].b, dir[i].q, (i == 0) ? 5 : (i % 3), $sformatf("dir%0d", i));

    // Reset four cycles into DIVIDE aborts the operation.
    in_valid = 1'b1;
    lhs = 8'h40;
    rhs = 8'h60;
    @(negedge clk);
    in_valid = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check_eq("abort_in_ready", in_ready, 1);
    check_eq("abort_out_valid", out_valid, 0);
    check_eq("abort_quotient", quotient, 8'h00);
    seen = 1'b0;
    repeat (20) begin
      @(negedge clk);
      if (out_valid) seen = 1'b1;
    end
    out_ready = 1'b0;
    check_eq("abort_no_valid", seen, 0);
    do_op(8'h40, 8'h40, 8'h40, 1, "after_abort");

    for (int i = 0; i < 150; i++) begin
      a = 8'($urandom);
      b = 8'($urandom);
      if ($urandom_range(0, 9) == 0) a = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'h80;
      if ($urandom_range(0, 9) == 0) b = ($urandom_range(0, 1) != 0) ? 8'h00 : 8'h80;
      do_op(a, b, model_div(a, b), $urandom_range(0, 3), $sformatf("rnd%0d", i));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
